// File: rtl/johnson_decoder_if.sv
// Sample/result bundle between a Johnson-code source and johnson_decoder.
// The master drives samples and the slave (the decoder) returns decoded status.
interface johnson_decoder_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(2*WIDTH)
);
  logic [WIDTH-1:0] code_in;
  logic             code_valid;
  logic [CW-1:0]    count;
  logic             count_valid;
  logic             illegal;
  logic             seq_err;
  logic             locked;
  logic [7:0]       err_cnt;

  modport master (
    output code_in, code_valid,
    input  count, count_valid, illegal, seq_err, locked, err_cnt
  );

  modport slave (
    input  code_in, code_valid,
    output count, count_valid, illegal, seq_err, locked, err_cnt
  );
endinterface

// File: rtl/johnson_decoder.sv
// Decodes twisted-ring (Johnson) code samples to a step index and flags illegal
// codes and out-of-sequence steps; a lock FSM reports clean tracking.
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int CW       = $clog2(2*WIDTH)
) (
  input logic               clk,
  input logic               rst,
  johnson_decoder_if.slave  bus
);
  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  state_t        state, state_n;
  logic [CW-1:0] prev, prev_n;
  logic [7:0]    run, run_n;
  logic [CW-1:0] count, count_n;
  logic          cv, cv_n, ill, ill_n, se, se_n;
  logic [7:0]    err_cnt, err_cnt_n;
  logic          err_inc;

  // Code classification: a Johnson code has at most one 0/1 boundary between
  // adjacent bits; its index follows from the popcount and the MSB.
  int unsigned   trans, pc;
  logic          legal;
  logic [CW-1:0] idx, prev_nxt;
  logic          succ, hold;
  logic [8:0]    run_inc;

  always_comb begin
    trans = 0;
    pc    = 0;
    for (int i = 0; i < WIDTH - 1; i++)
      trans = trans + int'(bus.code_in[i] ^ bus.code_in[i+1]);
    for (int i = 0; i < WIDTH; i++)
      pc = pc + int'(bus.code_in[i]);
    legal = (trans <= 1);
    if (bus.code_in[WIDTH-1]) idx = CW'(pc);
    else if (pc == 0)          idx = '0;
    else                       idx = CW'(2*WIDTH - int'(pc));
    prev_nxt = (prev == CW'(2*WIDTH - 1)) ? '0 : prev + CW'(1);
    succ     = (idx == prev_nxt);
    hold     = (idx == prev);
    run_inc  = {1'b0, run} + 9'd1;
  end

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    count_n = count;
    cv_n    = 1'b0;
    ill_n   = 1'b0;
    se_n    = 1'b0;
    err_inc = 1'b0;
    if (bus.code_valid) begin
      if (!legal) begin
        ill_n   = 1'b1;
        err_inc = 1'b1;
        state_n = ACQUIRE;
      end else begin
        cv_n    = 1'b1;
        count_n = idx;
        prev_n  = idx;
        case (state)
          ACQUIRE: begin
            run_n   = '0;
            state_n = TRACK;
          end
          TRACK: begin
            if (succ) begin
              run_n = run_inc[7:0];
              if (run_inc == 9'(LOCK_LEN)) state_n = LOCKED;
            end else if (!hold) begin
              run_n = '0;
            end
          end
          LOCKED: begin
            if (!succ && !hold) begin
              se_n    = 1'b1;
              err_inc = 1'b1;
              run_n   = '0;
              state_n = TRACK;
            end
          end
          default: state_n = ACQUIRE;
        endcase
      end
    end
    err_cnt_n = (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACQUIRE;
      prev    <= '0;
      run     <= '0;
      count   <= '0;
      cv      <= 1'b0;
      ill     <= 1'b0;
      se      <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      run     <= run_n;
      count   <= count_n;
      cv      <= cv_n;
      ill     <= ill_n;
      se      <= se_n;
      err_cnt <= err_cnt_n;
    end
  end

  assign bus.count       = count;
  assign bus.count_valid = cv;
  assign bus.illegal     = ill;
  assign bus.seq_err     = se;
  assign bus.locked      = (state == LOCKED);
  assign bus.err_cnt     = err_cnt;
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Decodes and checks the 4-bit twisted-ring code produced by the team's Johnson counter. Sampled codes are converted to a binary step index, and illegal codes and out-of-sequence transitions are flagged. A lock state machine reports when the incoming stream is tracking cleanly. The block sits on the receive side of any Johnson-coded phase or sequencer bus, e.g. next to a monitor or a clock-domain-safe state transfer.

## Interface

- WIDTH, 4, Johnson register width N (N >= 2); the sequence has 2N states
- LOCK_LEN, 4, number of consecutive successor transitions required to assert lock (1..255)
- CW, $clog2(2*WIDTH), derived, width of the count output (3 for WIDTH=4)

- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- code_in  input  WIDTH  Johnson code sample; bit WIDTH-1 is the first stage
- code_valid  input  1  code_in is sampled on this cycle
- count  output  CW  decoded step index of last legal sample
- count_valid  output  1  one-cycle pulse: count updated from a legal sample
- illegal  output  1  one-cycle pulse: sampled code not a legal Johnson code
- seq_err  output  1  one-cycle pulse: legal but non-successor code while LOCKED
- locked  output  1  level: state is LOCKED
- err_cnt  output  8  saturating count of illegal + seq_err events

## Operation

- Legal sequence (WIDTH=4), index 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then wraps to 0000. This is a right shift with ~LSB fed into the MSB.
- Legal code: either 1s contiguous from the MSB followed by 0s, or 0s contiguous from the MSB followed by 1s. This gives exactly 2N codes.
- Decode: MSB=1 gives index = popcount. MSB=0 gives index = (2N - popcount) mod 2N, so all-zero decodes to 0.
- Successor: new index == (prev index + 1) mod 2N. The wrap from 2N-1 to 0 is a successor.
- Hold: new index == prev index. It is neither a successor nor an error, and run is unchanged.
- Samples with code_valid=0 are ignored. No state changes and no pulses.
- State machine, with registers prev (CW bits) and run (8 bits):
  - ACQUIRE:
    - Legal sample: prev=index, run=0, go to TRACK.
    - Illegal sample: illegal pulse, err_cnt++, stay in ACQUIRE.
  - TRACK:
    - Successor: run++. If run+1 == LOCK_LEN, go to LOCKED.
    - Hold: no change.
    - Legal non-successor: prev=index, run=0, stay in TRACK, no seq_err.
    - Illegal: illegal pulse, err_cnt++, go to ACQUIRE.
  - LOCKED:
    - Successor or hold: stay in LOCKED.
    - Legal non-successor: seq_err pulse, err_cnt++, prev=index, run=0, go to TRACK.
    - Illegal: illegal pulse, err_cnt++, go to ACQUIRE.
- prev is updated on every legal sample in every state.
- illegal and seq_err are never asserted in the same cycle.
- err_cnt saturates at 255 and is cleared only by rst.

## Timing

- Latency: a sample taken at edge k produces count, count_valid, illegal, seq_err and the new locked value, all registered and visible after edge k+1.
- count_valid fires for every legal valid sample, including holds. count holds its value otherwise.
- Lock timing: the first legal sample is followed by LOCK_LEN successors. locked rises with the count_valid of the LOCK_LEN-th successor, which is the 5th sample for the default.
- locked falls in the same cycle as the illegal or seq_err pulse that caused the exit.
- Reset:
  - rst high at any edge forces state ACQUIRE, prev=0, run=0.
  - All outputs go to 0 (count=0, count_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0).
  - rst takes priority over code_valid. A reset in the middle of a lock drops locked on the next edge.
- Back-to-back valid samples are supported every cycle with no bubbles.

## Test plan

- Reset: hold rst for 2 cycles with code_valid=1 and code_in=1010 -> all outputs 0; no illegal pulse.
- Clean stream: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000 on consecutive cycles -> count 0,1,2,3,4,5,6,7,0, with count_valid high each cycle. locked rises with count=4 and stays high through the 0001->0000 wrap. err_cnt stays 0.
- Illegal while locked: after lock, send 1010 -> illegal pulse, locked=0, err_cnt=1, count unchanged. Then send 0011 -> count=6, TRACK.
- Skip while locked: after lock at 1100, send 1111 -> seq_err pulse, locked=0, count=4, err_cnt=1. Four further successors (0111, 0011, 0001, 0000) -> locked again.
- Hold and gaps: while locked, repeat 1110 three times and interleave code_valid=0 cycles carrying garbage (0101) -> no pulses on invalid cycles, locked stays 1, count=3.
- Saturation and reset mid-run: send 300 illegal samples -> err_cnt=255. Assert rst during the next locked stream -> err_cnt=0 and locked=0 one edge later.
